// File: rtl/apple_bus_host.sv
// apple_bus_host: Apple II slot-bus initiator clocked from C7M.
// Generates PHI0/PHI1, the address bus, R/W, the slot select strobes and the data
// bus drive for one slot. Transactions are fed through a req/ack port. The bus runs
// free, with idle cycles whenever no request is pending.
//
// Ports:
//   C7M, RES             - 7 MHz bus clock and async active-high reset
//   req, we, addr, wdata - transaction request (sampled at the end of each bus cycle)
//   busy, ack, rdata     - accepted-not-done flag, completion pulse, read data
//   PHI0, PHI1           - bus phases
//   A, nWE               - address bus and R/W (low = write)
//   D_in, D_out, D_oe    - data bus
//   nDEVSEL, nIOSEL, nIOSTRB - active-low slot selects
module apple_bus_host #(
  parameter int unsigned SLOT       = 4,
  parameter int unsigned LONG_EVERY = 65,
  parameter logic [15:0] IDLE_ADDR  = 16'hFFFF
) (
  input  logic        C7M,
  input  logic        RES,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        PHI0,
  output logic        PHI1,
  output logic [15:0] A,
  output logic        nWE,
  input  logic [7:0]  D_in,
  output logic [7:0]  D_out,
  output logic        D_oe,
  output logic        nDEVSEL,
  output logic        nIOSEL,
  output logic        nIOSTRB
);

  localparam int unsigned CntW = (LONG_EVERY > 1) ? $clog2(LONG_EVERY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LONG_EVERY - 1);
  localparam logic [3:0] SlotNib = 4'(SLOT);
  localparam logic [3:0] DevNib  = 4'(8 + SLOT);

  // Bus state index: 0 = S1 ... 7 = S8 (S8 exists only on long cycles).
  logic [2:0]      s_q, s_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phi1_q, phi1_d, phi0_q, phi0_d;
  logic [15:0]     a_q, a_d, addr_q, addr_d;
  logic            nwe_q, nwe_d, we_q, we_d;
  logic [7:0]      wdata_q, wdata_d, d_out_q, d_out_d, rdata_q, rdata_d;
  logic            d_oe_q, d_oe_d, busy_q, busy_d, ack_q, ack_d;
  logic            ndevsel_q, ndevsel_d, niosel_q, niosel_d, niostrb_q, niostrb_d;

  logic long_cyc, last, accept;
  logic dev_hit, io_hit, strb_hit;

  always_comb begin
    long_cyc = (cnt_q == CntLast);
    last     = ((s_q == 3'd6) && !long_cyc) || (s_q == 3'd7);
    // busy always clears at the same edge it is checked, so back-to-back acceptance
    // only needs req high when leaving the final state.
    accept   = last && req;
    dev_hit  = (addr_q[15:4] == {8'hC0, DevNib});
    io_hit   = (addr_q[15:8] == {4'hC, SlotNib});
    strb_hit = (addr_q[15:11] == 5'b11001);

    s_d       = last ? 3'd0 : s_q + 3'd1;
    cnt_d     = cnt_q;
    a_d       = a_q;
    nwe_d     = nwe_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    d_out_d   = d_out_q;
    d_oe_d    = d_oe_q;
    rdata_d   = rdata_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    ndevsel_d = ndevsel_q;
    niosel_d  = niosel_q;
    niostrb_d = niostrb_q;

    if (last) begin
      cnt_d     = long_cyc ? '0 : cnt_q + 1'b1;
      ack_d     = busy_q;
      if (busy_q) rdata_d = we_q ? 8'h00 : D_in;
      busy_d    = accept;
      if (accept) begin
        addr_d  = addr;
        we_d    = we;
        wdata_d = wdata;
      end
      a_d       = accept ? addr : IDLE_ADDR;
      nwe_d     = accept ? ~we : 1'b1;
      ndevsel_d = 1'b1;
      niosel_d  = 1'b1;
      niostrb_d = 1'b1;
      d_oe_d    = 1'b0;
    end else if ((s_q == 3'd2) && busy_q) begin
      // Entering S4.
      ndevsel_d = ~dev_hit;
      niosel_d  = ~io_hit;
      niostrb_d = ~strb_hit;
    end else if ((s_q == 3'd3) && busy_q && we_q) begin
      // Entering S5.
      d_oe_d  = 1'b1;
      d_out_d = wdata_q;
    end

    phi1_d = (s_d < 3'd3);
    phi0_d = ~phi1_d;
  end

  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      s_q       <= 3'd0;
      cnt_q     <= '0;
      phi1_q    <= 1'b1;
      phi0_q    <= 1'b0;
      a_q       <= IDLE_ADDR;
      nwe_q     <= 1'b1;
      addr_q    <= 16'h0000;
      we_q      <= 1'b0;
      wdata_q   <= 8'h00;
      d_out_q   <= 8'h00;
      d_oe_q    <= 1'b0;
      rdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      ndevsel_q <= 1'b1;
      niosel_q  <= 1'b1;
      niostrb_q <= 1'b1;
    end else begin
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      phi1_q    <= phi1_d;
      phi0_q    <= phi0_d;
      a_q       <= a_d;
      nwe_q     <= nwe_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      ndevsel_q <= ndevsel_d;
      niosel_q  <= niosel_d;
      niostrb_q <= niostrb_d;
    end
  end

  assign PHI1    = phi1_q;
  assign PHI0    = phi0_q;
  assign A       = a_q;
  assign nWE     = nwe_q;
  assign D_out   = d_out_q;
  assign D_oe    = d_oe_q;
  assign busy    = busy_q;
  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign nDEVSEL = ndevsel_q;
  assign nIOSEL  = niosel_q;
  assign nIOSTRB = niostrb_q;

endmodule
